io_port_hub: RTL and testbench

IO_PORT_HUB -- requirements
Module: io_port_hub

---
 rtl/io_hub_pkg.sv | 18 +
 rtl/io_port_hub_if.sv | 33 +++
 rtl/sync_fifo.sv | 53 +++++
 rtl/io_port_hub.sv | 103 ++++++++++
 tb/tb_io_port_hub.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_hub_pkg.sv
// Shared constants and helpers for the processor I/O port hub.
// Defaults are port counts, data widths and FIFO depth; is_onehot validates address-decoder strobes.
package io_hub_pkg;

  localparam int DEF_NPIN  = 4;
  localparam int DEF_NPOUT = 4;
  localparam int DEF_NBIN  = 19;
  localparam int DEF_NBOUT = 28;
  localparam int DEF_DEPTH = 4;

  // Strobe vectors are zero-extended to this width before the one-hot check.
  localparam int MAX_SEL = 32;

  function automatic logic is_onehot(input logic [MAX_SEL-1:0] v);
    return (v != '0) && ((v & (v - {{(MAX_SEL-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/io_port_hub_if.sv
// Bundle of processor-side strobes, external stream handshakes and sticky status for io_port_hub.
// valid/ready: a word moves on a rising edge where valid and ready are both high; valid never waits on ready.
interface io_port_hub_if #(
  parameter int NPIN  = io_hub_pkg::DEF_NPIN,
  parameter int NPOUT = io_hub_pkg::DEF_NPOUT,
  parameter int NBIN  = io_hub_pkg::DEF_NBIN,
  parameter int NBOUT = io_hub_pkg::DEF_NBOUT
);
  logic [NPIN-1:0]        req_in;
  logic [NBIN-1:0]        io_in;
  logic [NPOUT-1:0]       out_en;
  logic [NBOUT-1:0]       io_out;
  logic [NPIN*NBIN-1:0]   s_data;
  logic [NPIN-1:0]        s_valid;
  logic [NPIN-1:0]        s_ready;
  logic [NPOUT*NBOUT-1:0] m_data;
  logic [NPOUT-1:0]       m_valid;
  logic [NPOUT-1:0]       m_ready;
  logic                   clr;
  logic [NPIN-1:0]        udf;
  logic [NPOUT-1:0]       ovf;
  logic                   sel_err;

  modport master (
    output req_in, out_en, io_out, s_data, s_valid, m_ready, clr,
    input  io_in, s_ready, m_data, m_valid, udf, ovf, sel_err
  );

  modport slave (
    input  req_in, out_en, io_out, s_data, s_valid, m_ready, clr,
    output io_in, s_ready, m_data, m_valid, udf, ovf, sel_err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; head reads 0 while empty so stale storage never leaks.
// A push while full is taken only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; the counter alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/io_port_hub.sv
// Bridges one-hot processor read/write strobes to per-port stream FIFOs in both directions.
// Reads are zero-latency: io_in shows the selected head and the pop happens on the same edge.
module io_port_hub
  import io_hub_pkg::*;
#(
  parameter int NPIN  = DEF_NPIN,
  parameter int NPOUT = DEF_NPOUT,
  parameter int NBIN  = DEF_NBIN,
  parameter int NBOUT = DEF_NBOUT,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic            clk,
  input logic            rst,
  io_port_hub_if.slave   bus
);
  logic                   rd_onehot;
  logic                   wr_onehot;
  logic                   sel_evt;
  logic [NPIN-1:0]        in_full, in_empty, in_push, in_pop, udf_evt;
  logic [NBIN-1:0]        in_head [NPIN];
  logic [NPOUT-1:0]       out_full, out_empty, out_push, out_pop, ovf_evt;
  logic [NBOUT-1:0]       out_head [NPOUT];
  logic [NBIN-1:0]        io_mux;
  logic [NPOUT*NBOUT-1:0] m_data_w;
  logic [NPIN-1:0]        udf_q;
  logic [NPOUT-1:0]       ovf_q;
  logic                   sel_err_q;

  assign rd_onehot = is_onehot(MAX_SEL'(bus.req_in));
  assign wr_onehot = is_onehot(MAX_SEL'(bus.out_en));
  assign sel_evt   = ((|bus.req_in) & ~rd_onehot) | ((|bus.out_en) & ~wr_onehot);

  for (genvar i = 0; i < NPIN; i++) begin : g_in
    // A full FIFO refuses the source even when the processor pops it this cycle.
    assign in_push[i] = bus.s_valid[i] & ~in_full[i];
    assign in_pop[i]  = rd_onehot & bus.req_in[i] & ~in_empty[i];
    assign udf_evt[i] = rd_onehot & bus.req_in[i] & in_empty[i];

    sync_fifo #(.WIDTH(NBIN), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_push[i]),
      .data  (bus.s_data[i*NBIN +: NBIN]),
      .pop   (in_pop[i]),
      .head  (in_head[i]),
      .full  (in_full[i]),
      .empty (in_empty[i])
    );
  end

  for (genvar j = 0; j < NPOUT; j++) begin : g_out
    assign out_push[j] = wr_onehot & bus.out_en[j];
    assign out_pop[j]  = ~out_empty[j] & bus.m_ready[j];
    assign ovf_evt[j]  = out_push[j] & out_full[j] & ~out_pop[j];

    sync_fifo #(.WIDTH(NBOUT), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (out_push[j]),
      .data  (bus.io_out),
      .pop   (out_pop[j]),
      .head  (out_head[j]),
      .full  (out_full[j]),
      .empty (out_empty[j])
    );
  end

  always_comb begin
    io_mux = '0;
    for (int i = 0; i < NPIN; i++) begin
      if (in_pop[i]) io_mux = io_mux | in_head[i];
    end
  end

  always_comb begin
    m_data_w = '0;
    for (int j = 0; j < NPOUT; j++) begin
      m_data_w[j*NBOUT +: NBOUT] = out_head[j];
    end
  end

  // Sticky flags: an event on the same edge as clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      udf_q     <= '0;
      ovf_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      udf_q     <= (udf_q & ~{NPIN{bus.clr}}) | udf_evt;
      ovf_q     <= (ovf_q & ~{NPOUT{bus.clr}}) | ovf_evt;
      sel_err_q <= (sel_err_q & ~bus.clr) | sel_evt;
    end
  end

  assign bus.io_in   = io_mux;
  assign bus.s_ready = ~in_full;
  assign bus.m_valid = ~out_empty;
  assign bus.m_data  = m_data_w;
  assign bus.udf     = udf_q;
  assign bus.ovf     = ovf_q;
  assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_io_port_hub.sv
// Directed bench for io_port_hub: zero-latency reads, underflow/overflow, multi-hot strobes and async reset.
// Expected values are hand-computed; output-port drain order is checked against an expected queue.
module tb_io_port_hub;
  import io_hub_pkg::*;

  localparam int NPIN  = DEF_NPIN;
  localparam int NPOUT = DEF_NPOUT;
  localparam int NBIN  = DEF_NBIN;
  localparam int NBOUT = DEF_NBOUT;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [NBIN-1:0]  m7;
  logic [NBOUT-1:0] m1;
  logic [NBOUT-1:0] exp_w;
  logic [NBOUT-1:0] exp_q[$];

  io_port_hub_if bus ();

  io_port_hub dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m7 = NBIN'(-7);
    m1 = NBOUT'(-1);
    rst = 1'b0;
    bus.req_in  = '0;
    bus.out_en  = '0;
    bus.io_out  = '0;
    bus.s_data  = '0;
    bus.s_valid = '0;
    bus.m_ready = '0;
    bus.clr     = 1'b0;

    // reset state
    #2;
    chk("rst_s_ready", 64'(bus.s_ready), 64'hF);
    chk("rst_m_valid", 64'(bus.m_valid), 64'h0);
    chk("rst_m_data_zero", 64'(bus.m_data == '0), 64'd1);
    chk("rst_flags", 64'({bus.udf, bus.ovf, bus.sel_err}), 64'h0);
    #10 rst = 1'b1;
    tick();

    // port 1: push 5, -7 then two reads
    bus.s_valid = 4'b0010;
    bus.s_data[NBIN +: NBIN] = NBIN'(5);
    tick();
    bus.s_data[NBIN +: NBIN] = m7;
    tick();
    bus.s_valid = '0;
    chk("p1_s_ready", 64'(bus.s_ready[1]), 64'd1);
    bus.req_in = 4'b0010;
    #1 chk("p1_rd0", 64'(bus.io_in), 64'd5);
    tick();
    chk("p1_rd1", 64'(bus.io_in), 64'(m7));
    chk("p1_s_ready_rd", 64'(bus.s_ready[1]), 64'd1);
    tick();
    bus.req_in = '0;
    #1 chk("p1_no_udf", 64'(bus.udf), 64'h0);

    // port 0: fill, then pop while source still offers a word
    bus.s_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      bus.s_data[0 +: NBIN] = NBIN'(10 + k);
      tick();
    end
    chk("p0_full", 64'(bus.s_ready[0]), 64'd0);
    bus.s_data[0 +: NBIN] = NBIN'(99);
    bus.req_in = 4'b0001;
    #1 chk("p0_rd_full", 64'(bus.io_in), 64'd10);
    chk("p0_full_pop_ready", 64'(bus.s_ready[0]), 64'd0);
    tick();
    bus.s_valid = '0;
    bus.req_in  = '0;
    #1 chk("p0_ready_after", 64'(bus.s_ready[0]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      bus.req_in = 4'b0001;
      #1 chk("p0_drain", 64'(bus.io_in), 64'(11 + k));
      tick();
    end
    bus.req_in = 4'b0001;
    #1 chk("p0_empty_rd", 64'(bus.io_in), 64'd0);
    tick();
    bus.req_in = '0;
    chk("p0_udf", 64'(bus.udf), 64'h1);
    clr_pulse();
    chk("p0_udf_clr", 64'(bus.udf), 64'h0);

    // port 3 underflow, clear, and clear coincident with event
    bus.req_in = 4'b1000;
    #1 chk("p3_empty_rd", 64'(bus.io_in), 64'd0);
    tick();
    bus.req_in = '0;
    chk("p3_udf", 64'(bus.udf), 64'h8);
    clr_pulse();
    chk("p3_udf_clr", 64'(bus.udf), 64'h0);
    bus.req_in = 4'b1000;
    bus.clr = 1'b1;
    tick();
    bus.req_in = '0;
    bus.clr = 1'b0;
    chk("p3_udf_clr_coinc", 64'(bus.udf), 64'h8);
    clr_pulse();

    // port 2: empty, push and read on the same edge
    bus.s_valid = 4'b0100;
    bus.s_data[2*NBIN +: NBIN] = NBIN'(77);
    bus.req_in = 4'b0100;
    #1 chk("p2_push_rd_empty", 64'(bus.io_in), 64'd0);
    tick();
    bus.s_valid = '0;
    bus.req_in  = '0;
    chk("p2_udf", 64'(bus.udf), 64'h4);
    bus.req_in = 4'b0100;
    #1 chk("p2_stored", 64'(bus.io_in), 64'd77);
    tick();
    bus.req_in = '0;
    clr_pulse();

    // output port 2: five writes into depth 4, one dropped
    bus.out_en = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      bus.io_out = NBOUT'(k + 1);
      tick();
    end
    bus.out_en = '0;
    chk("o2_valid", 64'(bus.m_valid), 64'h4);
    chk("o2_head", 64'(bus.m_data[2*NBOUT +: NBOUT]), 64'd1);
    chk("o2_ovf", 64'(bus.ovf), 64'h4);
    for (int k = 1; k <= 4; k++) exp_q.push_back(NBOUT'(k));
    bus.m_ready = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      exp_w = exp_q.pop_front();
      chk("o2_drain_valid", 64'(bus.m_valid[2]), 64'd1);
      chk("o2_drain_data", 64'(bus.m_data[2*NBOUT +: NBOUT]), 64'(exp_w));
      tick();
    end
    bus.m_ready = '0;
    chk("o2_empty", 64'(bus.m_valid[2]), 64'd0);
    chk("o2_empty_data", 64'(bus.m_data[2*NBOUT +: NBOUT]), 64'd0);

    // output port 1: write into full FIFO while it pops is accepted
    bus.out_en = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      bus.io_out = NBOUT'(100 + k);
      tick();
    end
    bus.m_ready = 4'b0010;
    bus.io_out  = m1;
    tick();
    bus.out_en  = '0;
    bus.m_ready = '0;
    chk("o1_no_ovf", 64'(bus.ovf), 64'h4);
    exp_q.push_back(NBOUT'(101));
    exp_q.push_back(NBOUT'(102));
    exp_q.push_back(NBOUT'(103));
    exp_q.push_back(m1);
    bus.m_ready = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      exp_w = exp_q.pop_front();
      chk("o1_drain_data", 64'(bus.m_data[NBOUT +: NBOUT]), 64'(exp_w));
      tick();
    end
    bus.m_ready = '0;
    chk("o1_empty", 64'(bus.m_valid), 64'h0);

    // multi-hot strobes
    bus.s_valid = 4'b0011;
    bus.s_data[0 +: NBIN]    = NBIN'(21);
    bus.s_data[NBIN +: NBIN] = NBIN'(22);
    tick();
    bus.s_valid = '0;
    bus.req_in  = 4'b0011;
    #1 chk("multi_rd_io_in", 64'(bus.io_in), 64'd0);
    tick();
    bus.req_in = '0;
    chk("multi_sel_err", 64'(bus.sel_err), 64'd1);
    bus.req_in = 4'b0001;
    #1 chk("multi_p0_kept", 64'(bus.io_in), 64'd21);
    tick();
    bus.req_in = 4'b0010;
    #1 chk("multi_p1_kept", 64'(bus.io_in), 64'd22);
    tick();
    bus.req_in = '0;
    bus.out_en = 4'b0011;
    bus.io_out = NBOUT'(5);
    tick();
    bus.out_en = '0;
    chk("multi_wr_no_push", 64'(bus.m_valid), 64'h0);

    // queue words everywhere, then asynchronous reset between edges
    for (int k = 0; k < 12; k++) begin
      bus.s_valid = (k < 4) ? 4'hF : 4'h0;
      bus.s_data  = {NPIN{NBIN'(k + 1)}};
      bus.out_en  = 4'(1 << (k % 4));
      bus.io_out  = NBOUT'(k + 200);
      tick();
    end
    bus.s_valid = '0;
    bus.out_en  = '0;
    chk("pre_rst_s_ready", 64'(bus.s_ready), 64'h0);
    chk("pre_rst_m_valid", 64'(bus.m_valid), 64'hF);
    #2 rst = 1'b0;
    #1;
    chk("arst_s_ready", 64'(bus.s_ready), 64'hF);
    chk("arst_m_valid", 64'(bus.m_valid), 64'h0);
    chk("arst_m_data_zero", 64'(bus.m_data == '0), 64'd1);
    chk("arst_flags", 64'({bus.udf, bus.ovf, bus.sel_err}), 64'h0);
    #3 rst = 1'b1;
    tick();
    bus.req_in = 4'b0001;
    #1 chk("post_rst_empty", 64'(bus.io_in), 64'd0);
    tick();
    bus.req_in = '0;
    chk("post_rst_udf", 64'(bus.udf), 64'h1);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
